cart_load_ctrl: RTL
===================

Name: cart_load_ctrl

Overview:
Controller sitting between the HPS download stream and the cartridge RAM. It sequences each ROM download: optional RAM clear, byte writes, power-of-two address-mask computation, then a hold-off core reset. Outside downloads it hands the RAM read port to the CPU. It replaces the ad-hoc reset timer and mask logic in the top level with one sequenced block.

Parameters:
ADDR_W, 15, cart RAM address width (RAM depth 2^ADDR_W bytes)
HOLD_CYCLES, 12000000, core_reset hold length in clk_sys cycles after any reset source clears
DL_ADDR_W, 25, width of download address bus

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high block reset
rst_req  in  1  external reset request (menu/button/OSD), level
dl_active  in  1  download in progress (level)
dl_wr  in  1  download byte strobe, one cycle per byte
dl_addr  in  DL_ADDR_W  download byte address
dl_data  in  8  download byte
dl_wait  out  1  stall to HPS; no dl_wr accepted while high
cpu_addr  in  ADDR_W  CPU cart read address (pre-masked by CPU side)
cpu_dout  out  8  CPU read data, 1-cycle latency
ram_addr  out  ADDR_W  cart RAM address
ram_din  out  8  cart RAM write data
ram_we  out  1  cart RAM write enable
ram_dout  in  8  cart RAM read data (1-cycle synchronous RAM)
cart_mask  out  ADDR_W  address mask, 2^n-1 covering highest written address
core_reset  out  1  reset to vectrex core
overflow  out  1  sticky: a download byte had dl_addr >= 2^ADDR_W

Behaviour:
- One clock, clk_sys; reset synchronous, active-high.
- Reset values: state=HOLD, hold counter=0, cart_mask=0, core_reset=1, dl_wait=0, ram_we=0, overflow=0, cpu_dout=0.
- States: RUN, CLEAR, LOAD, HOLD. core_reset=1 in CLEAR, LOAD, HOLD; 0 only in RUN.
- Download start = dl_active rising edge (registered previous value). From any state: cart_mask<=0, overflow<=0, go CLEAR (macro on) or LOAD (macro off).
- LOAD: on dl_wr with dl_addr < 2^ADDR_W: ram_we=1, ram_addr=dl_addr[ADDR_W-1:0], ram_din=dl_data registered (write 1 cycle after strobe). If (dl_addr[ADDR_W-1:0] & ~cart_mask)!=0, cart_mask<=(cart_mask<<1)|1; one step per byte; saturates at all ones. dl_addr >= 2^ADDR_W: no write, overflow<=1, mask unchanged.
- dl_wr in the same cycle dl_active falls is still written. dl_active falling -> HOLD, counter<=0.
- Empty download (no dl_wr): cart_mask stays 0.
- HOLD: counter increments each cycle; at counter==HOLD_CYCLES-1 -> RUN next cycle. rst_req high in HOLD or RUN: counter<=0, state HOLD (held while rst_req stays high). rst_req ignored in CLEAR/LOAD.
- RUN: ram_addr=cpu_addr, ram_we=0, cpu_dout=ram_dout (valid 1 cycle after cpu_addr). In other states cpu_dout holds last value.
- dl_wait=0 outside CLEAR.
- Simultaneous: download start beats rst_req; reset beats everything.

Optional Feature:
CART_CLEAR_EN. Defined: CLEAR state writes 0x00 to addresses 0..2^ADDR_W-1, one per cycle, dl_wait=1 throughout; after last address -> LOAD, dl_wait=0 the cycle LOAD is entered. dl_active falling during CLEAR aborts to HOLD. Undefined: CLEAR state absent, start goes straight to LOAD, dl_wait tied 0; stale bytes beyond new image remain.

Decomposition:
- Package cart_load_pkg: state enum (RUN, CLEAR, LOAD, HOLD), default ADDR_W, HOLD_CYCLES constants, mask-step function.
- Sub-module cart_hold_timer: counter with clear/enable and done output, width $clog2(HOLD_CYCLES).

Test Plan:
- Reset with HOLD_CYCLES=16, no inputs -> core_reset high exactly 16 cycles after reset drops, then RUN; cart_mask=0.
- Download 8 KB at addresses 0..0x1FFF -> 8192 ram_we pulses, data matches, cart_mask=0x1FFF, core_reset falls 16 cycles after dl_active falls.
- Download 5000 bytes -> cart_mask=0x1FFF; download 1 byte at addr 0 -> cart_mask=0x0000.
- Byte at dl_addr=0x8000 (ADDR_W=15) -> no write, overflow=1; next download start clears overflow.
- rst_req pulsed 3 cycles in RUN -> core_reset high, deasserts 16 cycles after rst_req falls; CPU read of addr 0x0010 in RUN returns written byte one cycle later.
- CART_CLEAR_EN, ADDR_W=4: start -> dl_wait high 16 cycles, RAM all 0x00; dl_active dropped at clear cycle 5 -> HOLD, no LOAD writes.

Source files
------------

// File: rtl/cart_load_pkg.sv
// cart_load_pkg: shared types and constants for the cartridge download controller.
//   cart_state_e : controller state encoding (RUN, CLEAR, LOAD, HOLD)
//   ADDR_W_DEF, HOLD_CYCLES_DEF : default parameter values
//   mask_step()  : grows a 2^n-1 address mask by one bit
package cart_load_pkg;

  localparam int ADDR_W_DEF      = 15;
  localparam int HOLD_CYCLES_DEF = 12000000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } cart_state_e;

  // Caller truncates to its address width; an all-ones mask stays all ones,
  // which gives saturation for free.
  function automatic logic [31:0] mask_step(input logic [31:0] mask);
    return {mask[30:0], 1'b1};
  endfunction

endpackage

// File: rtl/cart_load_ctrl_if.sv
// cart_load_ctrl_if: HPS download stream into the cartridge controller.
//   dl_active : download in progress (level)
//   dl_wr     : one-cycle byte strobe
//   dl_addr   : byte address, DL_ADDR_W bits
//   dl_data   : byte value
//   dl_wait   : stall back to the HPS
// master = HPS side, slave = controller side.
interface cart_load_ctrl_if #(
  parameter int DL_ADDR_W = 25
);
  logic                 dl_active;
  logic                 dl_wr;
  logic [DL_ADDR_W-1:0] dl_addr;
  logic [7:0]           dl_data;
  logic                 dl_wait;

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    input  dl_wait
  );

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    output dl_wait
  );
endinterface

// File: rtl/cart_hold_timer.sv
// cart_hold_timer: core-reset hold-off counter.
//   clk_sys, reset : clock, synchronous active-high reset
//   clr            : restart count from 0 (wins over en)
//   en             : advance count by one
//   done           : count has reached HOLD_CYCLES-1
module cart_hold_timer #(
  parameter int HOLD_CYCLES = 12000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/cart_load_ctrl.sv
// cart_load_ctrl: sequences ROM downloads into cartridge RAM and gates the
// vectrex core reset. Outside downloads the RAM read port belongs to the CPU.
//   clk_sys, reset   : clock, synchronous active-high reset
//   rst_req          : external reset request (level)
//   dl               : download stream (cart_load_ctrl_if.slave)
//   cpu_addr/cpu_dout: CPU cart read port, 1-cycle read latency
//   ram_*            : cart RAM port (synchronous 1-cycle read)
//   cart_mask        : 2^n-1 mask covering the highest written address
//   core_reset       : core reset, low only in RUN
//   overflow         : sticky, a byte addressed beyond the RAM was dropped
// Build option: define CART_CLEAR_EN to zero the whole RAM before each load.
//
// state | meaning
// RUN   | core running, CPU owns the RAM read port
// CLEAR | zeroing RAM one byte per cycle, HPS stalled
// LOAD  | accepting download bytes
// HOLD  | core held in reset until the hold timer expires
module cart_load_ctrl
  import cart_load_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int DL_ADDR_W   = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              rst_req,
  cart_load_ctrl_if.slave   dl,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] cart_mask,
  output logic              core_reset,
  output logic              overflow
);

  cart_state_e       state_q, state_d;
  logic              dl_active_q;
  logic [ADDR_W-1:0] cart_mask_q, cart_mask_d;
  logic              overflow_q, overflow_d;
  logic              wr_we_q, wr_we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_din_q, wr_din_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
`ifdef CART_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

  logic hold_clr, hold_en, hold_done;
  logic dl_start, dl_in_range;

  assign dl_start    = dl.dl_active & ~dl_active_q;
  assign dl_in_range = (dl.dl_addr[DL_ADDR_W-1:ADDR_W] == '0);

  cart_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (hold_clr),
    .en      (hold_en),
    .done    (hold_done)
  );

  always_comb begin
    state_d     = state_q;
    cart_mask_d = cart_mask_q;
    overflow_d  = overflow_q;
    wr_we_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_din_d    = wr_din_q;
    hold_clr    = 1'b0;
    hold_en     = 1'b0;
`ifdef CART_CLEAR_EN
    clr_addr_d  = clr_addr_q;
`endif

    case (state_q)
      CLEAR: begin
`ifdef CART_CLEAR_EN
        clr_addr_d = clr_addr_q + 1'b1;
        if (!dl.dl_active) begin
          state_d  = HOLD;
          hold_clr = 1'b1;
        end else if (clr_addr_q == '1) begin
          state_d = LOAD;
        end
`else
        state_d  = HOLD;
        hold_clr = 1'b1;
`endif
      end
      LOAD: begin
        // A strobe coinciding with dl_active falling is still taken.
        if (dl.dl_wr) begin
          if (dl_in_range) begin
            wr_we_d   = 1'b1;
            wr_addr_d = dl.dl_addr[ADDR_W-1:0];
            wr_din_d  = dl.dl_data;
            if ((dl.dl_addr[ADDR_W-1:0] & ~cart_mask_q) != '0) begin
              cart_mask_d = ADDR_W'(mask_step(32'(cart_mask_q)));
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (!dl.dl_active) begin
          state_d  = HOLD;
          hold_clr = 1'b1;
        end
      end
      HOLD: begin
        if (rst_req) begin
          hold_clr = 1'b1;
        end else if (hold_done) begin
          state_d = RUN;
        end else begin
          hold_en = 1'b1;
        end
      end
      default: begin
        if (rst_req) begin
          state_d  = HOLD;
          hold_clr = 1'b1;
        end
      end
    endcase

    // A new download overrides whatever the state logic decided.
    if (dl_start) begin
      cart_mask_d = '0;
      overflow_d  = 1'b0;
`ifdef CART_CLEAR_EN
      state_d     = CLEAR;
      clr_addr_d  = '0;
`else
      state_d     = LOAD;
`endif
    end
  end

  // CPU read data is taken from the RAM only for addresses presented in RUN;
  // otherwise the last value is held.
  assign rd_valid_d = (state_q == RUN);
  assign cpu_dout   = rd_valid_q ? ram_dout : cpu_dout_q;
  assign cpu_dout_d = cpu_dout;

  always_comb begin
    ram_addr = wr_addr_q;
    ram_din  = wr_din_q;
    ram_we   = wr_we_q;
    if (state_q == RUN) begin
      ram_addr = cpu_addr;
    end
`ifdef CART_CLEAR_EN
    if (state_q == CLEAR) begin
      ram_addr = clr_addr_q;
      ram_din  = 8'h00;
      ram_we   = 1'b1;
    end
`endif
  end

`ifdef CART_CLEAR_EN
  assign dl.dl_wait = (state_q == CLEAR);
`else
  assign dl.dl_wait = 1'b0;
`endif

  assign cart_mask  = cart_mask_q;
  assign overflow   = overflow_q;
  assign core_reset = (state_q != RUN);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= HOLD;
      dl_active_q <= 1'b0;
      cart_mask_q <= '0;
      overflow_q  <= 1'b0;
      wr_we_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_din_q    <= '0;
      rd_valid_q  <= 1'b0;
      cpu_dout_q  <= '0;
`ifdef CART_CLEAR_EN
      clr_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dl_active_q <= dl.dl_active;
      cart_mask_q <= cart_mask_d;
      overflow_q  <= overflow_d;
      wr_we_q     <= wr_we_d;
      wr_addr_q   <= wr_addr_d;
      wr_din_q    <= wr_din_d;
      rd_valid_q  <= rd_valid_d;
      cpu_dout_q  <= cpu_dout_d;
`ifdef CART_CLEAR_EN
      clr_addr_q  <= clr_addr_d;
`endif
    end
  end

endmodule
